// File: rtl/obu_header_parser.sv
// Byte-serial AV1 OBU framer: header, optional extension, LEB128 obu_size, payload passthrough.
// Define OBU_EXT_EN to decode temporal_id/spatial_id from the extension byte.
module obu_header_parser #(
  parameter int MAX_LEB_BYTES = 8,
  parameter int SIZE_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              hdr_valid,
  output logic [3:0]        obu_type,
  output logic              obu_has_ext,
  output logic [2:0]        temporal_id,
  output logic [1:0]        spatial_id,
  output logic [SIZE_W-1:0] obu_size,
  output logic              error,
  input  logic              clear
);

  // state | meaning
  // HDR   | waiting for OBU header byte
  // EXT   | waiting for extension byte
  // SIZE  | accumulating LEB128 obu_size bytes
  // PAY   | passing payload bytes downstream
  // ERR   | framing error, stalled until clear
  typedef enum logic [2:0] {HDR, EXT, SIZE, PAY, ERR} state_t;

  localparam int IDX_W  = (MAX_LEB_BYTES > 1) ? $clog2(MAX_LEB_BYTES) : 1;
  localparam int WIDE_W = SIZE_W + 7 * MAX_LEB_BYTES;

  state_t              state_q, state_d;
  logic [3:0]          stg_type_q, stg_type_d;
  logic                stg_ext_q, stg_ext_d;
  logic [2:0]          stg_tid_q, stg_tid_d;
  logic [1:0]          stg_sid_q, stg_sid_d;
  logic [SIZE_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SIZE_W-1:0]   rem_q, rem_d;
  logic                hdr_valid_q, hdr_valid_d;
  logic [3:0]          type_q, type_d;
  logic                ext_q, ext_d;
  logic [2:0]          tid_q, tid_d;
  logic [1:0]          sid_q, sid_d;
  logic [SIZE_W-1:0]   size_q, size_d;

  logic                accept;
  logic [IDX_W+2:0]    shamt;
  logic [WIDE_W-1:0]   shifted;
  logic                overflow;
  logic                last_idx;
  logic [SIZE_W-1:0]   acc_next;

  assign in_ready  = !clear && ((state_q == HDR) || (state_q == EXT) || (state_q == SIZE) ||
                                ((state_q == PAY) && out_ready));
  assign out_valid = !clear && (state_q == PAY) && in_valid;
  assign out_last  = !clear && (state_q == PAY) && (rem_q == SIZE_W'(1));
  assign out_data  = in_data;
  assign accept    = in_valid && in_ready;
  assign error     = (state_q == ERR);

  // 7*i computed as 8*i - i to keep the shift amount a plain vector
  assign shamt    = {idx_q, 3'b000} - {3'b000, idx_q};
  assign shifted  = WIDE_W'(in_data[6:0]) << shamt;
  assign overflow = |shifted[WIDE_W-1:SIZE_W];
  assign last_idx = (idx_q == IDX_W'(MAX_LEB_BYTES - 1));
  assign acc_next = acc_q | shifted[SIZE_W-1:0];

  always_comb begin
    state_d     = state_q;
    stg_type_d  = stg_type_q;
    stg_ext_d   = stg_ext_q;
    stg_tid_d   = stg_tid_q;
    stg_sid_d   = stg_sid_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    hdr_valid_d = 1'b0;
    type_d      = type_q;
    ext_d       = ext_q;
    tid_d       = tid_q;
    sid_d       = sid_q;
    size_d      = size_q;
    case (state_q)
      HDR: if (accept) begin
        stg_type_d = in_data[6:3];
        stg_ext_d  = in_data[2];
        stg_tid_d  = 3'd0;
        stg_sid_d  = 2'd0;
        acc_d      = '0;
        idx_d      = '0;
        if (in_data[7] || !in_data[1]) state_d = ERR;
        else                           state_d = in_data[2] ? EXT : SIZE;
      end
      EXT: if (accept) begin
`ifdef OBU_EXT_EN
        stg_tid_d = in_data[7:5];
        stg_sid_d = in_data[4:3];
`endif
        state_d = SIZE;
      end
      SIZE: if (accept) begin
        if (overflow || (in_data[7] && last_idx)) begin
          state_d = ERR;
        end else if (in_data[7]) begin
          acc_d = acc_next;
          idx_d = idx_q + IDX_W'(1);
        end else begin
          acc_d       = acc_next;
          rem_d       = acc_next;
          size_d      = acc_next;
          type_d      = stg_type_q;
          ext_d       = stg_ext_q;
          tid_d       = stg_tid_q;
          sid_d       = stg_sid_q;
          hdr_valid_d = 1'b1;
          state_d     = (acc_next == '0) ? HDR : PAY;
        end
      end
      PAY: if (accept) begin
        rem_d = rem_q - SIZE_W'(1);
        if (rem_q == SIZE_W'(1)) state_d = HDR;
      end
      ERR: state_d = ERR;
      default: state_d = HDR;
    endcase
    if (clear) state_d = HDR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HDR;
      stg_type_q  <= '0;
      stg_ext_q   <= 1'b0;
      stg_tid_q   <= '0;
      stg_sid_q   <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      hdr_valid_q <= 1'b0;
      type_q      <= '0;
      ext_q       <= 1'b0;
      tid_q       <= '0;
      sid_q       <= '0;
      size_q      <= '0;
    end else begin
      state_q     <= state_d;
      stg_type_q  <= stg_type_d;
      stg_ext_q   <= stg_ext_d;
      stg_tid_q   <= stg_tid_d;
      stg_sid_q   <= stg_sid_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      hdr_valid_q <= hdr_valid_d;
      type_q      <= type_d;
      ext_q       <= ext_d;
      tid_q       <= tid_d;
      sid_q       <= sid_d;
      size_q      <= size_d;
    end
  end

  assign hdr_valid   = hdr_valid_q;
  assign obu_type    = type_q;
  assign obu_has_ext = ext_q;
  assign temporal_id = tid_q;
  assign spatial_id  = sid_q;
  assign obu_size    = size_q;

endmodule
